// File: rtl/q_pulse_serializer_if.sv
// Valid/ready charge-value channel between a charge source and q_pulse_serializer.
interface q_pulse_serializer_if #(
    parameter int BUS_WIDTH = 10
);
    logic [BUS_WIDTH-1:0] q_value;
    logic                 q_valid;
    logic                 q_ready;

    modport master (output q_value, output q_valid, input q_ready);
    modport slave  (input q_value, input q_valid, output q_ready);
endinterface

// File: rtl/q_pulse_serializer.sv
// Charge-to-pulse-train transmitter: emits floor(Q / Q_PER_PULSE) fixed-width pulses
// on q_serialized, each followed by an enable-gated low gap.
module q_pulse_serializer #(
    parameter int BUS_WIDTH      = 10,
    parameter int PULSE_DURATION = 3,
    parameter int GAP_DURATION   = 3,
    parameter int Q_PER_PULSE    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    q_pulse_serializer_if.slave  q_if,
    output logic                 q_serialized,
    output logic                 busy,
    output logic                 pulses_ended,
    output logic [BUS_WIDTH-1:0] pulses_left
);
    localparam int MAX_DUR = (PULSE_DURATION > GAP_DURATION) ? PULSE_DURATION : GAP_DURATION;
    localparam int TW      = $clog2(MAX_DUR + 1);

    localparam logic [TW-1:0]        PD_LOAD = TW'(PULSE_DURATION - 1);
    localparam logic [TW-1:0]        GD_LOAD = TW'(GAP_DURATION - 1);
    localparam logic [TW-1:0]        T_ONE   = TW'(1);
    localparam logic [BUS_WIDTH-1:0] L_ONE   = BUS_WIDTH'(1);
    localparam logic [BUS_WIDTH-1:0] QPP     = BUS_WIDTH'(Q_PER_PULSE);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [TW-1:0]        timer, timer_nxt;
    logic [BUS_WIDTH-1:0] left_nxt;
    logic [BUS_WIDTH-1:0] quotient;
    logic                 ready_int;
    logic                 handshake;

    // Holding reset keeps q_ready low so a value offered during reset is not seen as taken.
    assign ready_int   = (state == IDLE) && enable && !rst;
    assign q_if.q_ready = ready_int;
    assign handshake   = ready_int && q_if.q_valid;
    assign quotient    = q_if.q_value / QPP;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        left_nxt  = pulses_left;
        case (state)
            IDLE: begin
                if (handshake) begin
                    left_nxt  = quotient;
                    timer_nxt = PD_LOAD;
                    state_nxt = (quotient == '0) ? DONE : HIGH;
                end
            end
            HIGH: begin
                // Pulse width is fixed: enable has no effect here.
                if (timer == '0) begin
                    timer_nxt = GD_LOAD;
                    state_nxt = LOW;
                end else begin
                    timer_nxt = timer - T_ONE;
                end
            end
            LOW: begin
                if (enable) begin
                    if (timer == '0) begin
                        left_nxt  = pulses_left - L_ONE;
                        timer_nxt = PD_LOAD;
                        state_nxt = (pulses_left == L_ONE) ? DONE : HIGH;
                    end else begin
                        timer_nxt = timer - T_ONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered images of the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            pulses_left  <= '0;
            q_serialized <= 1'b0;
            busy         <= 1'b0;
            pulses_ended <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            pulses_left  <= left_nxt;
            q_serialized <= (state_nxt == HIGH);
            busy         <= (state_nxt == HIGH) || (state_nxt == LOW);
            pulses_ended <= (state_nxt == DONE);
        end
    end
endmodule

// File: tb/tb_q_pulse_serializer.sv
// Self-checking bench for q_pulse_serializer: expected pulse trains are built from
// the pulse/gap rules and compared cycle by cycle, plus frame-level checks.
module tb_q_pulse_serializer;
    localparam int BW = 10;
    localparam int PD = 3;
    localparam int GD = 3;
    localparam int T  = PD + GD;

    logic clk = 1'b0;
    logic rst;
    logic enable;

    logic          ser_a, busy_a, ended_a;
    logic [BW-1:0] left_a;
    logic          ser_b, busy_b, ended_b;
    logic [BW-1:0] left_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    q_pulse_serializer_if #(.BUS_WIDTH(BW)) if_a ();
    q_pulse_serializer_if #(.BUS_WIDTH(BW)) if_b ();

    q_pulse_serializer #(.BUS_WIDTH(BW), .PULSE_DURATION(PD), .GAP_DURATION(GD), .Q_PER_PULSE(1)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .q_if(if_a),
        .q_serialized(ser_a), .busy(busy_a), .pulses_ended(ended_a), .pulses_left(left_a)
    );

    q_pulse_serializer #(.BUS_WIDTH(BW), .PULSE_DURATION(PD), .GAP_DURATION(GD), .Q_PER_PULSE(4)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .q_if(if_b),
        .q_serialized(ser_b), .busy(busy_b), .pulses_ended(ended_b), .pulses_left(left_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic en_at(int t, int s, int l);
        return !(l > 0 && t >= s && t < s + l);
    endfunction

    // Drive one frame of value v on dut_a; enable is low for samples s..s+l-1 after the handshake.
    task automatic run_frame(input int v, input int s, input int l, input string name);
        logic [12:0] exp_q[$];
        logic [12:0] obs;
        int t;
        int g;
        int budget;
        t = 0;
        for (int p = 0; p < v; p++) begin
            for (int h = 0; h < PD; h++) begin
                exp_q.push_back({1'b1, 1'b1, 1'b0, BW'(v - p)});
                t++;
            end
            g = 0;
            while (g < GD) begin
                exp_q.push_back({1'b0, 1'b1, 1'b0, BW'(v - p)});
                if (en_at(t, s, l)) g++;
                t++;
            end
        end
        exp_q.push_back({3'b001, BW'(0)});

        enable = 1'b1;
        #1;
        budget = 0;
        while (if_a.q_ready !== 1'b1 && budget < 50) begin
            step();
            budget++;
        end
        n_checks++;
        if (if_a.q_ready !== 1'b1) begin
            $display("FAIL %s ready_wait: q_ready=%b expected 1", name, if_a.q_ready);
            n_fail++;
        end
        if_a.q_value = BW'(v);
        if_a.q_valid = 1'b1;
        step();
        if_a.q_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = {ser_a, busy_a, ended_a, left_a};
            n_checks++;
            if (obs !== exp_q[i]) begin
                $display("FAIL %s v=%0d t=%0d {ser,busy,ended,left}: got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         name, v, i, obs[12], obs[11], obs[10], obs[9:0],
                         exp_q[i][12], exp_q[i][11], exp_q[i][10], exp_q[i][9:0]);
                n_fail++;
            end
            enable = en_at(i, s, l);
            step();
        end
        enable = 1'b1;
        #1;
        n_checks++;
        if ({if_a.q_ready, ended_a, ser_a, busy_a} !== 4'b1000) begin
            $display("FAIL %s post_frame {ready,ended,ser,busy}: got %b expected 1000", name,
                     {if_a.q_ready, ended_a, ser_a, busy_a});
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        if_a.q_value = BW'(7);
        if_a.q_valid = 1'b1;
        step();
        step();
        n_checks++;
        if ({ser_a, busy_a, ended_a, left_a, if_a.q_ready} !== '0) begin
            $display("FAIL reset_values: ser=%b busy=%b ended=%b left=%0d ready=%b expected all 0",
                     ser_a, busy_a, ended_a, left_a, if_a.q_ready);
            n_fail++;
        end
        rst = 1'b0;
        if_a.q_valid = 1'b0;
        #1;
        n_checks++;
        if (if_a.q_ready !== 1'b1) begin
            $display("FAIL reset_ready_follows_enable: q_ready=%b expected 1", if_a.q_ready);
            n_fail++;
        end
        step();
        n_checks++;
        if (busy_a !== 1'b0 || ser_a !== 1'b0) begin
            $display("FAIL reset_drops_value: busy=%b ser=%b expected 0/0", busy_a, ser_a);
            n_fail++;
        end
        enable = 1'b0;
        #1;
        n_checks++;
        if (if_a.q_ready !== 1'b0) begin
            $display("FAIL ready_gated_by_enable: q_ready=%b expected 0", if_a.q_ready);
            n_fail++;
        end
        enable = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        run_frame(5, 0, 0, "basic_five");
    endtask

    task automatic test_stall();
        run_frame(4, 7, 7, "stall_mid_high");
    endtask

    task automatic test_reset_mid_frame();
        logic saw_end;
        enable = 1'b1;
        if_a.q_value = BW'(8);
        if_a.q_valid = 1'b1;
        step();
        if_a.q_valid = 1'b0;
        repeat (13) step();
        n_checks++;
        if (ser_a !== 1'b1) begin
            $display("FAIL midreset_in_pulse3: ser=%b expected 1", ser_a);
            n_fail++;
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({ser_a, busy_a, ended_a, left_a} !== '0) begin
            $display("FAIL midreset_clear: ser=%b busy=%b ended=%b left=%0d expected 0/0/0/0",
                     ser_a, busy_a, ended_a, left_a);
            n_fail++;
        end
        rst = 1'b0;
        saw_end = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ended_a === 1'b1 || busy_a === 1'b1) saw_end = 1'b1;
            step();
        end
        n_checks++;
        if (saw_end !== 1'b0) begin
            $display("FAIL midreset_no_end: saw ended/busy=%b expected 0", saw_end);
            n_fail++;
        end
        run_frame(3, 0, 0, "post_reset");
    endtask

    task automatic run_b(input int v);
        int t;
        int cnt;
        logic prev;
        logic [BW-1:0] left0;
        enable = 1'b1;
        #1;
        n_checks++;
        if (if_b.q_ready !== 1'b1) begin
            $display("FAIL qpp_ready v=%0d: q_ready=%b expected 1", v, if_b.q_ready);
            n_fail++;
        end
        if_b.q_value = BW'(v);
        if_b.q_valid = 1'b1;
        step();
        if_b.q_valid = 1'b0;
        left0 = left_b;
        t = 0;
        cnt = 0;
        prev = 1'b0;
        while (ended_b !== 1'b1 && t < 4000) begin
            if (ser_b === 1'b1 && prev === 1'b0) cnt++;
            prev = ser_b;
            step();
            t++;
        end
        n_checks++;
        if (t !== (v / 4) * T || cnt !== v / 4) begin
            $display("FAIL qpp v=%0d: end_t=%0d pulses=%0d expected end_t=%0d pulses=%0d",
                     v, t, cnt, (v / 4) * T, v / 4);
            n_fail++;
        end
        n_checks++;
        if (left0 !== BW'(v / 4)) begin
            $display("FAIL qpp_left v=%0d: pulses_left=%0d expected %0d", v, left0, v / 4);
            n_fail++;
        end
        step();
    endtask

    task automatic test_q_per_pulse();
        run_b(10);
        run_b(3);
        run_b(1023);
    endtask

    task automatic test_back_to_back();
        int vals [3];
        int idx, frame, cnt, cyc, last_fall;
        logic prev, accept;
        vals = '{20, 30, 40};
        enable = 1'b1;
        idx = 0;
        frame = 0;
        cnt = 0;
        cyc = 0;
        last_fall = -1;
        prev = 1'b0;
        if_a.q_value = BW'(vals[0]);
        if_a.q_valid = 1'b1;
        #1;
        while (frame < 3 && cyc < 2000) begin
            if (ser_a === 1'b1 && prev === 1'b0) begin
                cnt++;
                if (cnt == 1 && last_fall >= 0) begin
                    n_checks++;
                    if (cyc - last_fall < GD + 2) begin
                        $display("FAIL b2b_gap frame=%0d: low time %0d expected >= %0d",
                                 frame, cyc - last_fall, GD + 2);
                        n_fail++;
                    end
                end
            end
            if (ser_a === 1'b0 && prev === 1'b1) last_fall = cyc;
            prev = ser_a;
            if (ended_a === 1'b1) begin
                n_checks++;
                if (cnt !== vals[frame]) begin
                    $display("FAIL b2b_count frame=%0d: pulses=%0d expected %0d", frame, cnt, vals[frame]);
                    n_fail++;
                end
                frame++;
                cnt = 0;
            end
            accept = if_a.q_ready && if_a.q_valid;
            step();
            cyc++;
            if (accept) begin
                idx++;
                if (idx < 3) if_a.q_value = BW'(vals[idx]);
                else if_a.q_valid = 1'b0;
            end
        end
        if_a.q_valid = 1'b0;
        n_checks++;
        if (frame !== 3 || idx !== 3) begin
            $display("FAIL b2b_frames: frames=%0d accepted=%0d expected 3/3", frame, idx);
            n_fail++;
        end
        step();
    endtask

    task automatic test_boundaries();
        run_frame(0, 0, 0, "zero");
        run_frame(1, 0, 0, "one");
        run_frame(1023, 0, 0, "max");
    endtask

    task automatic test_random();
        int v, s, l;
        repeat (18) begin
            v = int'($urandom_range(380, 20));
            s = int'($urandom_range(60, 0));
            l = int'($urandom_range(8, 0));
            run_frame(v, s, l, "random");
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        if_a.q_value = '0;
        if_a.q_valid = 1'b0;
        if_b.q_value = '0;
        if_b.q_valid = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid_frame();
        test_q_per_pulse();
        test_back_to_back();
        test_boundaries();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end
endmodule
